// File: rtl/cnt_pkg.sv
// Shared types and helpers for sync_updown_counter: prescaler sizing,
// count direction and the modulus-aware next-count function.
package cnt_pkg;

   localparam int unsigned CNT_MAX_W  = 32;
   localparam int unsigned CNT_WORD_W = CNT_MAX_W + 1;

   typedef logic [CNT_WORD_W-1:0] cnt_word_t;

   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } cnt_dir_t;

   localparam cnt_word_t CNT_ZERO = 33'd0;
   localparam cnt_word_t CNT_ONE  = 33'd1;

   function automatic int unsigned cnt_psc_width(input int unsigned prescale);
      int unsigned w_v;
      if (prescale > 32'd1) begin
         w_v = unsigned'($clog2(prescale));
      end else begin
         w_v = 32'd1;
      end
      return w_v;
   endfunction

   // Compares against the modulus in a word wider than any count, so a
   // non-power-of-two range never depends on natural register overflow.
   function automatic cnt_word_t cnt_next(input cnt_word_t count,
                                          input cnt_dir_t  dir,
                                          input logic      sat,
                                          input cnt_word_t modulus);
      cnt_word_t last_v;
      cnt_word_t next_v;
      last_v = modulus - CNT_ONE;
      case (dir)
         CNT_UP: begin
            if (count >= last_v) begin
               next_v = sat ? last_v : CNT_ZERO;
            end else begin
               next_v = count + CNT_ONE;
            end
         end
         CNT_DOWN: begin
            if (count == CNT_ZERO) begin
               next_v = sat ? CNT_ZERO : last_v;
            end else begin
               next_v = count - CNT_ONE;
            end
         end
         default: next_v = CNT_ZERO;
      endcase
      return next_v;
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable divider for sync_updown_counter: tick fires on every PRESCALE-th
// enabled cycle; a parallel load restarts the division.
module cnt_prescaler
   import cnt_pkg::*;
#(
   parameter int unsigned PRESCALE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic load,
   output logic tick
);

   localparam int unsigned     PW       = cnt_psc_width(PRESCALE);
   localparam logic [PW-1:0]   PSC_LAST = PW'(PRESCALE - 32'd1);
   localparam logic [PW-1:0]   PSC_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0]   PSC_ONE  = PW'(32'd1);

   logic [PW-1:0] psc_r;
   logic          at_last_s;

   // Tick decode from the current prescaler phase
   always_comb begin
      at_last_s = (psc_r == PSC_LAST);
      tick      = en & at_last_s;
   end

   // Prescaler phase: load restarts, enable advances, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_r <= PSC_ZERO;
      end else if (load) begin
         psc_r <= PSC_ZERO;
      end else if (en) begin
         if (at_last_s) begin
            psc_r <= PSC_ZERO;
         end else begin
            psc_r <= psc_r + PSC_ONE;
         end
      end else begin
         psc_r <= psc_r;
      end
   end

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with modulus, load, saturate,
// prescaler and cascadable tc. Optional sticky ovf under CNT_STICKY_OVF_EN.
module sync_updown_counter
   import cnt_pkg::*;
#(
   parameter int unsigned     WIDTH    = 4,
   parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
   parameter int unsigned     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc
`ifdef CNT_STICKY_OVF_EN
   ,
   output logic             ovf,
   input  logic             ovf_clr
`endif
);

   localparam cnt_word_t MOD_W  = cnt_word_t'(MODULUS);
   localparam cnt_word_t TERM_W = MOD_W - CNT_ONE;

   logic [WIDTH-1:0] count_r;
   cnt_word_t        count_w_s;
   cnt_word_t        load_w_s;
   cnt_word_t        load_clamp_s;
   cnt_word_t        next_w_s;
   cnt_dir_t         dir_s;
   logic             tick_s;
   logic             at_term_s;
   logic             tc_s;
   logic             unused_ok_s;

   generate
      if (PRESCALE > 1) begin : g_psc
         cnt_prescaler #(
            .PRESCALE(PRESCALE)
         ) u_psc (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .load  (load),
            .tick  (tick_s)
         );
      end else begin : g_bypass
         assign tick_s = en;
      end
   endgenerate

   // Widen count and load value so every compare sees the full modulus
   always_comb begin
      count_w_s              = CNT_ZERO;
      count_w_s[WIDTH-1:0]   = count_r;
      load_w_s               = CNT_ZERO;
      load_w_s[WIDTH-1:0]    = load_val;
   end

   // Next value, load clamp, terminal detect and tc strobe
   always_comb begin
      dir_s    = cnt_dir_t'(up);
      next_w_s = cnt_next(count_w_s, dir_s, sat, MOD_W);
      if (load_w_s > TERM_W) begin
         load_clamp_s = TERM_W;
      end else begin
         load_clamp_s = load_w_s;
      end
      if (up) begin
         at_term_s = (count_w_s == TERM_W);
      end else begin
         at_term_s = (count_w_s == CNT_ZERO);
      end
      // rst_n gates tc so a reset stage never strobes its cascade neighbour
      tc_s = rst_n & tick_s & at_term_s & ~load;
   end

   // Count register: load beats step beats hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {WIDTH{1'b0}};
      end else if (load) begin
         count_r <= load_clamp_s[WIDTH-1:0];
      end else if (tick_s) begin
         count_r <= next_w_s[WIDTH-1:0];
      end else begin
         count_r <= count_r;
      end
   end

   assign unused_ok_s = ^{load_clamp_s, next_w_s};
   assign count       = count_r;
   assign tc          = tc_s;

`ifdef CNT_STICKY_OVF_EN
   logic ovf_r;

   // Sticky overflow: a terminal-count cycle outranks a clear request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (tc_s) begin
         ovf_r <= 1'b1;
      end else if (ovf_clr) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule
